word_tx_arbiter: RTL

//  Round-robin arbiter that shares one 32-bit UART word transmitter among NUM_REQ requesters
//  (e.g. operand echo, product result, status word).

---
 rtl/word_tx_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/word_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit word transmitter among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining WORD_TX_ARB_TIMEOUT_EN.
module word_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TIMEOUT_CLKS = 4_000_000
) (
    input  logic                    i_Clock,
    input  logic                    i_Rst_n,
    input  logic [NUM_REQ-1:0]      i_Req,
    input  logic [32*NUM_REQ-1:0]   i_Req_Data,
    output logic [NUM_REQ-1:0]      o_Ack,
    output logic                    o_Busy,
    output logic [2:0]              o_Grant_Idx,
    output logic                    o_Word_Start,
    output logic [31:0]             o_Word_Data,
    input  logic                    i_Word_Done,
    output logic                    o_Timeout
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS == 0) begin : g_param_check
        $error("word_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CLKS nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   grant_q;
`ifdef WORD_TX_ARB_TIMEOUT_EN
    logic [31:0]        timer_q;
`endif

    logic [WORD_W-1:0]  req_word_c [NUM_REQ];
    logic               win_valid_c;
    logic [SEL_W-1:0]   win_sel_c;

    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req_word_c[k] = i_Req_Data[k*WORD_W +: WORD_W];
        end
    end

    // First requesting index after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned cand;
        win_valid_c = 1'b0;
        win_sel_c   = '0;
        cand        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!win_valid_c && i_Req[SEL_W'(cand)]) begin
                win_valid_c = 1'b1;
                win_sel_c   = SEL_W'(cand);
            end
        end
    end

    assign o_Grant_Idx = IDX_W'(grant_q);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= SEL_W'(NUM_REQ - 1);
            grant_q      <= '0;
            o_Ack        <= '0;
            o_Busy       <= 1'b0;
            o_Word_Start <= 1'b0;
            o_Word_Data  <= '0;
            o_Timeout    <= 1'b0;
`ifdef WORD_TX_ARB_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            o_Word_Start <= 1'b0;
            o_Ack        <= '0;
            o_Timeout    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_c) begin
                        grant_q      <= win_sel_c;
                        o_Word_Data  <= req_word_c[win_sel_c];
                        o_Word_Start <= 1'b1;
                        o_Busy       <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
`ifdef WORD_TX_ARB_TIMEOUT_EN
                    timer_q <= '0;
`endif
                end
                ST_WAIT: begin
                    // Done has priority over the watchdog on the same edge
                    if (i_Word_Done) begin
                        o_Ack   <= NUM_REQ'(1) << grant_q;
                        state_q <= ST_ACK;
                    end
`ifdef WORD_TX_ARB_TIMEOUT_EN
                    else if (timer_q == 32'(TIMEOUT_CLKS - 1)) begin
                        o_Ack     <= NUM_REQ'(1) << grant_q;
                        o_Timeout <= 1'b1;
                        state_q   <= ST_ACK;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
`endif
                end
                ST_ACK: begin
                    ptr_q   <= grant_q;
                    o_Busy  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    o_Busy  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
